instr_buffer_sched: RTL

Sequencer for the ESM instruction buffer. It accepts instruction words from the fetch side over a valid/ready handshake, stores them in a circular buffer of `bs` entries, and presents them in order to the execution side over a second valid/ready handshake. It owns all buffer indexing: separate write and read pointers, occupancy, full/empty, and flush. Storage is a write-enabled, synchronous-read RAM sub-module, so reads never overwrite stored entries.

---
 rtl/esm_pkg.sv | 13 +
 rtl/instr_buffer_sched_if.sv | 34 +++
 rtl/instr_buffer_ram.sv | 35 +++
 rtl/instr_buffer_sched.sv | 93 +++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared definitions for the ESM instruction buffer: default sizes and the
// output-stage state encoding.
package esm_pkg;

    localparam int INSTR_WORD_SIZE_DEF = 32;
    localparam int BS_DEF              = 16;

    typedef enum logic {
        OUT_EMPTY  = 1'b0,
        OUT_LOADED = 1'b1
    } out_state_t;

endpackage

// File: rtl/instr_buffer_sched_if.sv
// Fetch-side and execution-side handshake bundle of the instruction buffer.
// master = the environment (fetch + execute), slave = the buffer itself.
interface instr_buffer_sched_if
    import esm_pkg::*;
#(
    parameter int Instr_word_size = INSTR_WORD_SIZE_DEF,
    parameter int bs              = BS_DEF
);
    localparam int CW = $clog2(bs) + 1;

    // Both sides use plain valid/ready: a beat transfers on a rising edge where
    // valid && ready; a raised valid holds its data until ready is seen, and
    // ready never looks at valid.
    logic                       in_valid;
    logic                       in_ready;
    logic [Instr_word_size-1:0] Instr_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [Instr_word_size-1:0] Instr_out;
    logic [CW-1:0]              count;
    logic                       full;
    logic                       empty;

    modport master (
        output in_valid, Instr_in, out_ready,
        input  in_ready, out_valid, Instr_out, count, full, empty
    );

    modport slave (
        input  in_valid, Instr_in, out_ready,
        output in_ready, out_valid, Instr_out, count, full, empty
    );

endinterface

// File: rtl/instr_buffer_ram.sv
// Write-enabled storage with a registered read port that only updates on re,
// so the read register doubles as the buffer's output stage.
module instr_buffer_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only reset clears the read register; a flush leaves the stale word visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_buffer_sched.sv
// Instruction buffer sequencer: circular-buffer pointers, occupancy, flush and
// a one-entry output stage fed by the RAM's registered read port.
module instr_buffer_sched
    import esm_pkg::*;
#(
    parameter int Instr_word_size = INSTR_WORD_SIZE_DEF,
    parameter int bs              = BS_DEF  // power of two, at least 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    instr_buffer_sched_if.slave   bus,
    output out_state_t            out_state
);

    localparam int AW = $clog2(bs);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] mem_count;
    out_state_t    state;
    out_state_t    state_next;
    logic          wr_en;
    logic          re;
    logic          out_valid;
    logic          full;

    assign out_valid = (state == OUT_LOADED);
    assign full      = (mem_count == CW'(bs));

    // Space freed by a same-cycle read is not offered until the next cycle.
    assign bus.in_ready = !full && !flush;
    assign wr_en        = bus.in_valid && !full && !flush;
    assign re           = (mem_count != '0) && (!out_valid || bus.out_ready) && !flush;

    assign bus.out_valid = out_valid;
    assign bus.full      = full;
    assign bus.count     = mem_count + CW'(out_valid);
    assign bus.empty     = (bus.count == '0);
    assign out_state     = state;

    always_comb begin
        state_next = state;
        case (state)
            OUT_EMPTY: begin
                if (re) begin
                    state_next = OUT_LOADED;
                end
            end
            OUT_LOADED: begin
                if (bus.out_ready && !re) begin
                    state_next = OUT_EMPTY;
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            state     <= OUT_EMPTY;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (re) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            mem_count <= mem_count + CW'(wr_en) - CW'(re);
            state     <= state_next;
        end
    end

    instr_buffer_ram #(
        .W     (Instr_word_size),
        .DEPTH (bs),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.Instr_in),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (bus.Instr_out)
    );

endmodule
